// File: rtl/sdio_addr_ctlr_mc.sv
// sdio_addr_ctlr_mc: multi-channel SDIO address/count generator with byte-wise bank loads.
// Build option ACTL_WRAP_EN adds a per-channel aligned wrap mask used in incrementing mode.
module sdio_addr_ctlr_mc #(
   parameter int AWIDTH = 17,
   parameter int DWIDTH = 8,
   parameter int NCHAN = 8,
   parameter int CNTW = 9,
   parameter int BSWIDTH = 3,
   localparam int CHW = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
   input  logic               ACTL_Clk,
   input  logic               ACTL_RstN,
   input  logic [CHW-1:0]     ACTL_Chan,
   input  logic               ACTL_Load,
   input  logic [BSWIDTH-1:0] ACTL_BSel,
   input  logic [DWIDTH-1:0]  ACTL_Data_In,
   input  logic               ACTL_Start,
   input  logic               ACTL_Mode,
   input  logic               ACTL_Step,
   input  logic               ACTL_Abort,
   output logic [AWIDTH-1:0]  ACTL_Addr_Out,
   output logic [CNTW-1:0]    ACTL_Cnt_Out,
   output logic               ACTL_Busy,
   output logic               ACTL_Done
);
   localparam int NAB = (AWIDTH + DWIDTH - 1) / DWIDTH;
   localparam int NCB = (CNTW + DWIDTH - 1) / DWIDTH;
`ifdef ACTL_WRAP_EN
   localparam int NBANK = 2 * NAB + NCB;
`else
   localparam int NBANK = NAB + NCB;
`endif
   localparam int AP = NAB * DWIDTH;
   localparam int CP = NCB * DWIDTH;
   localparam logic [1:0] S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_DONE = 2'd2;

   if (NBANK > (1 << BSWIDTH)) begin : g_bank_chk
      $error("sdio_addr_ctlr_mc: bank count exceeds bank select range");
   end

   logic [AWIDTH-1:0] addr_r [NCHAN];
   logic [CNTW-1:0]   cnt_r  [NCHAN];
   logic [1:0]        state, nxt_state;
   logic [CHW-1:0]    act, out_ch;
   logic              mode_r, busy, go, step_ok, load_ok, last, sel_a, sel_c;
   logic [AWIDTH-1:0] cur_a, nxt_a, ld_a;
   logic [CNTW-1:0]   cur_c, ld_c;
   logic [AP-1:0]     apad;
   logic [CP-1:0]     cpad;
   int                bi;

   assign busy    = state == S_ACTIVE;
   assign go      = ACTL_Start && !busy;
   assign step_ok = busy && ACTL_Step && !ACTL_Abort;
   assign load_ok = ACTL_Load && !ACTL_Start && !(busy && ACTL_Chan == act);
   assign cur_a   = addr_r[act];
   assign cur_c   = cnt_r[act];
   assign last    = cur_c == CNTW'(1);
   assign bi      = int'(ACTL_BSel);
   assign sel_a   = bi < NAB;
   assign sel_c   = bi >= NAB && bi < NAB + NCB;
   assign nxt_state = go ? S_ACTIVE : !busy ? S_IDLE : ACTL_Abort ? S_IDLE :
                      (ACTL_Step && last) ? S_DONE : S_ACTIVE;

   // Byte-wide bank writes go through zero-padded copies so the top bank drops excess bits.
   always_comb begin
      apad = AP'(addr_r[ACTL_Chan]);
      cpad = CP'(cnt_r[ACTL_Chan]);
      apad[(sel_a ? bi : 0) * DWIDTH +: DWIDTH] = ACTL_Data_In;
      cpad[(sel_c ? bi - NAB : 0) * DWIDTH +: DWIDTH] = ACTL_Data_In;
      ld_a = apad[AWIDTH-1:0];
      ld_c = cpad[CNTW-1:0];
   end

`ifdef ACTL_WRAP_EN
   logic [AWIDTH-1:0] mask_r [NCHAN];
   logic [AWIDTH-1:0] cur_m, ld_m;
   logic [AP-1:0]     mpad;
   logic              sel_m;

   assign cur_m = mask_r[act];
   assign sel_m = bi >= NAB + NCB && bi < NBANK;
   assign nxt_a = mode_r ? cur_a : (cur_a & ~cur_m) | ((cur_a + 1'b1) & cur_m);

   always_comb begin
      mpad = AP'(mask_r[ACTL_Chan]);
      mpad[(sel_m ? bi - NAB - NCB : 0) * DWIDTH +: DWIDTH] = ACTL_Data_In;
      ld_m = mpad[AWIDTH-1:0];
   end

   always_ff @(posedge ACTL_Clk or negedge ACTL_RstN) begin
      if (!ACTL_RstN) begin
         for (int c = 0; c < NCHAN; c++) mask_r[c] <= '1;
      end else begin
         for (int c = 0; c < NCHAN; c++)
            if (load_ok && sel_m && ACTL_Chan == CHW'(c)) mask_r[c] <= ld_m;
      end
   end
`else
   assign nxt_a = mode_r ? cur_a : cur_a + 1'b1;
`endif

   always_ff @(posedge ACTL_Clk or negedge ACTL_RstN) begin
      if (!ACTL_RstN) begin
         state  <= S_IDLE;
         act    <= '0;
         mode_r <= 1'b0;
         for (int c = 0; c < NCHAN; c++) begin
            addr_r[c] <= '0;
            cnt_r[c]  <= '0;
         end
      end else begin
         state <= nxt_state;
         if (go) begin
            act    <= ACTL_Chan;
            mode_r <= ACTL_Mode;
         end
         for (int c = 0; c < NCHAN; c++) begin
            if (step_ok && act == CHW'(c)) begin
               addr_r[c] <= nxt_a;
               cnt_r[c]  <= cur_c - 1'b1;
            end else if (load_ok && ACTL_Chan == CHW'(c)) begin
               if (sel_a) addr_r[c] <= ld_a;
               if (sel_c) cnt_r[c] <= ld_c;
            end
         end
      end
   end

   assign out_ch        = busy ? act : ACTL_Chan;
   assign ACTL_Addr_Out = addr_r[out_ch];
   assign ACTL_Cnt_Out  = cnt_r[out_ch];
   assign ACTL_Busy     = busy;
   assign ACTL_Done     = state == S_DONE;
endmodule

// File: tb/tb_sdio_addr_ctlr_mc.sv
// tb_sdio_addr_ctlr_mc: scoreboard bench; driver pushes per-cycle expected outputs from a reference model.
module tb_sdio_addr_ctlr_mc;
   localparam int AMAX = (1 << 17) - 1;
   localparam int CMAX = (1 << 9) - 1;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic [2:0] chan = '0, bsel = '0;
   logic [7:0] din = '0;
   logic       load = 1'b0, start = 1'b0, mode = 1'b0, step = 1'b0, abort = 1'b0;
   logic [16:0] addr_o;
   logic [8:0]  cnt_o;
   logic        busy_o, done_o;

   sdio_addr_ctlr_mc dut (
      .ACTL_Clk(clk), .ACTL_RstN(rst_n), .ACTL_Chan(chan), .ACTL_Load(load),
      .ACTL_BSel(bsel), .ACTL_Data_In(din), .ACTL_Start(start), .ACTL_Mode(mode),
      .ACTL_Step(step), .ACTL_Abort(abort), .ACTL_Addr_Out(addr_o),
      .ACTL_Cnt_Out(cnt_o), .ACTL_Busy(busy_o), .ACTL_Done(done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit busy;
      bit done;
      int addr;
      int cnt;
   } exp_t;
   exp_t q[$];
   exp_t e;
   int checks = 0, errors = 0;

   int maddr[8], mcnt[8], mmask[8];
   bit mbusy, mdone, mmode;
   int mact;

   function automatic void chk(string n, int got, int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s t=%0t got %0h want %0h", n, $time, got, want);
      end
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < 8; c++) begin
         maddr[c] = 0;
         mcnt[c] = 0;
         mmask[c] = AMAX;
      end
      mbusy = 0; mdone = 0; mmode = 0; mact = 0;
   endfunction

   function automatic int put_byte(int v, int b, int d, int lim);
      return ((v & ~(255 << (8 * b))) | (d << (8 * b))) & lim;
   endfunction

   function automatic void model_edge();
      bit was_busy = mbusy;
      int c = int'(chan), b = int'(bsel);
      mdone = 0;
      if (was_busy) begin
         if (abort) mbusy = 0;
         else if (step) begin
            if (!mmode)
               maddr[mact] = ((maddr[mact] & ~mmask[mact]) | ((maddr[mact] + 1) & mmask[mact])) & AMAX;
            mcnt[mact] = (mcnt[mact] + CMAX) % (CMAX + 1);
            if (mcnt[mact] == 0) begin
               mbusy = 0;
               mdone = 1;
            end
         end
      end else if (start) begin
         mact = c;
         mmode = mode;
         mbusy = 1;
      end
      if (load && !start && !(was_busy && c == mact)) begin
         if (b < 3) maddr[c] = put_byte(maddr[c], b, din, AMAX);
         else if (b < 5) mcnt[c] = put_byte(mcnt[c], b - 3, din, CMAX);
`ifdef ACTL_WRAP_EN
         else mmask[c] = put_byte(mmask[c], b - 5, din, AMAX);
`endif
      end
   endfunction

   task automatic cyc();
      int oc;
      if (!rst_n) model_reset();
      oc = mbusy ? mact : int'(chan);
      q.push_back('{busy: mbusy, done: mdone, addr: maddr[oc], cnt: mcnt[oc]});
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge();
      #1;
      load = 0; start = 0; step = 0; abort = 0;
   endtask

   task automatic ld(int c, int b, int d);
      chan = 3'(c); bsel = 3'(b); din = 8'(d); load = 1; cyc();
   endtask

   task automatic go(int c, bit m);
      chan = 3'(c); mode = m; start = 1; cyc();
   endtask

   task automatic steps(int n);
      repeat (n) begin
         step = 1;
         cyc();
      end
   endtask

   task automatic idle(int n);
      repeat (n) cyc();
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("busy", int'(busy_o), int'(e.busy));
         chk("done", int'(done_o), int'(e.done));
         chk("addr", int'(addr_o), e.addr);
         chk("cnt", int'(cnt_o), e.cnt);
      end
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      cyc();
      rst_n = 1;
      for (int c = 0; c < 8; c++) begin
         chan = 3'(c);
         cyc();
      end
      // channel 3: 0x11234, count 4, incrementing
      ld(3, 0, 'h34); ld(3, 1, 'h12); ld(3, 2, 'h01); ld(3, 3, 'h04); ld(3, 4, 'h00);
      go(3, 0); steps(4); idle(2);
      // channel 1 wraps at the top of the address space
      ld(1, 0, 'hFF); ld(1, 1, 'hFF); ld(1, 2, 'h01); ld(1, 3, 2); ld(1, 4, 0);
      go(1, 0); steps(2); idle(2);
      // channel 0: count 0 means 512, fixed address
      ld(0, 0, 'h00); ld(0, 1, 'h05); ld(0, 2, 0); ld(0, 3, 0); ld(0, 4, 0);
      go(0, 1); steps(512); idle(2);
      // channel 2: abort wins over a simultaneous step
      ld(2, 0, 'h40); ld(2, 1, 0); ld(2, 2, 0); ld(2, 3, 10); ld(2, 4, 0);
      go(2, 0); steps(3);
      step = 1; abort = 1; cyc(); idle(2);
      // loads during a transfer: own channel blocked, other channel allowed
      ld(2, 3, 3);
      go(2, 0);
      ld(2, 0, 'h55); ld(5, 0, 'hAA);
      chan = 3'd2; steps(3); idle(1);
      chan = 3'd5; idle(1);
      // start accepted in the done cycle; unused banks and start+load collisions ignored
      ld(6, 3, 1); ld(7, 3, 2);
      go(6, 0); step = 1; cyc();
      go(7, 0); steps(2); idle(1);
      ld(4, 5, 'h12); ld(4, 7, 'h34);
      chan = 3'd4; bsel = 3'd0; din = 8'h99; load = 1; start = 1; mode = 0; cyc();
      steps(1); idle(2);
      // reset in the middle of a transfer
      ld(4, 3, 20); go(4, 0); steps(2);
      rst_n = 0; step = 1; cyc();
      rst_n = 1; idle(3);
`ifdef ACTL_WRAP_EN
      ld(6, 5, 'h0F); ld(6, 6, 0); ld(6, 7, 0);
      ld(6, 0, 'h0E); ld(6, 1, 'h01); ld(6, 2, 0); ld(6, 3, 3); ld(6, 4, 0);
      go(6, 0); steps(3); idle(2);
`endif
      for (int i = 0; i < 2500; i++) begin
         chan = 3'($urandom_range(0, 7));
         bsel = 3'($urandom_range(0, 7));
         din = 8'($urandom_range(0, 255));
         mode = 1'($urandom_range(0, 1));
         load = $urandom_range(0, 4) == 0;
         start = $urandom_range(0, 9) == 0;
         step = $urandom_range(0, 9) < 6;
         abort = $urandom_range(0, 39) == 0;
         cyc();
      end
      idle(2);
      @(negedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sdio_addr_ctlr_mc.md
Name: sdio_addr_ctlr_mc

Overview:
- Multi-channel, clocked SDIO address/count generator; successor to the single-channel strobe-driven address controller.
- Holds one address register and one transfer-count register per SDIO function (channel), loaded byte-wise through a bank select.
- Runs one transfer at a time, in incrementing or fixed-address mode, with a block/byte countdown and a completion pulse.
- Sits between the SDIO CMD52/CMD53 decoder, which loads and starts transfers, and the data-path sequencer, which steps them.

Parameters:
- AWIDTH, 17, address register width per channel.
- DWIDTH, 8, load data bus width.
- NCHAN, 8, number of channels.
- CNTW, 9, count register width; a loaded count of 0 means 2^CNTW transfers.
- BSWIDTH, 3, bank select width.
- Derived: CHW = clog2(NCHAN), NAB = ceil(AWIDTH/DWIDTH), NCB = ceil(CNTW/DWIDTH).
- Constraint: the total bank count must not exceed 2^BSWIDTH. Elaboration error otherwise.

Ports:
- ACTL_Clk  in  1  clock; all logic is on the rising edge.
- ACTL_RstN  in  1  reset, asynchronous assert, active-low.
- ACTL_Chan  in  CHW  channel addressed by Load and Start, and by Addr_Out when idle.
- ACTL_Load  in  1  loads ACTL_Data_In into the bank given by ACTL_BSel of ACTL_Chan.
- ACTL_BSel  in  BSWIDTH  banks 0..NAB-1 are address bytes (LSB first); NAB..NAB+NCB-1 are count bytes.
- ACTL_Data_In  in  DWIDTH  load data.
- ACTL_Start  in  1  single-cycle pulse; begins a transfer on ACTL_Chan.
- ACTL_Mode  in  1  sampled at Start; 0 = incrementing, 1 = fixed address.
- ACTL_Step  in  1  one data unit transferred on the active channel.
- ACTL_Abort  in  1  terminates the active transfer.
- ACTL_Addr_Out  out  AWIDTH  address of the active channel when busy, otherwise of ACTL_Chan.
- ACTL_Cnt_Out  out  CNTW  remaining count, selected the same way as ACTL_Addr_Out.
- ACTL_Busy  out  1  transfer in progress.
- ACTL_Done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset values:
  - all address and count registers 0;
  - active-channel register 0; mode 0;
  - Busy 0, Done 0; FSM in IDLE.
- Reset mid-transfer returns to IDLE immediately, with no Done pulse.
- Outputs are combinational muxes of the registers and reflect each edge's update in the same cycle.
- Load:
  - Writes the bits of the selected bank. Bits above AWIDTH/CNTW in the top bank are dropped.
  - Unused bank codes are ignored.
  - Ignored if ACTL_Chan equals the active channel while Busy, or if Start is asserted in the same cycle.
  - Loads to other channels are allowed while Busy.
- FSM IDLE:
  - Start latches ACTL_Chan as the active channel and latches ACTL_Mode.
  - Next state is ACTIVE and Busy=1 from the next cycle.
  - Step and Abort are ignored.
- FSM ACTIVE, Step:
  - The count decrements; 0 counts down to 2^CNTW-1.
  - If mode=0, the address increments modulo 2^AWIDTH (all ones wraps to 0). If mode=1, the address is held.
  - Registers are updated in place, so the channel resumes from its final address on a later transfer.
  - A Step that takes the count from 1 to 0 moves the FSM to DONE.
- FSM ACTIVE, Abort:
  - Next state is IDLE with no Done pulse; registers keep their current values.
  - Abort wins over a Step in the same cycle; that Step is discarded.
- FSM ACTIVE, Start: ignored.
- FSM DONE:
  - Done=1 and Busy=0 for exactly one cycle, then IDLE.
  - A Start in the DONE cycle is accepted, as from IDLE.
- Latency:
  - Start to Busy: 1 cycle.
  - Final Step to Done: 1 cycle.
  - Step to updated Addr_Out/Cnt_Out: 1 cycle.
- Throughput: one Step per cycle, back-to-back.

Optional Feature:
- Macro: ACTL_WRAP_EN.
- When defined:
  - Adds a per-channel wrap mask register at banks NAB+NCB..2*NAB+NCB-1, reset to all ones.
  - Incrementing mode computes new = (addr & ~mask) | ((addr+1) & mask), so the address wraps inside an aligned 2^k window (FIFO/ring targets).
  - Fixed mode is unchanged.
- When undefined:
  - Those bank codes are ignored.
  - Increment is plain modulo 2^AWIDTH.

Test Plan:
- Load channel 3: addr banks 0x34, 0x12, 0x01; count banks 0x04, 0x00. Start with mode=0, then 4 Steps. Required: addresses 0x11234→0x11238; Done pulse 1 cycle after the 4th Step; Busy low in that same cycle.
- Channel 1 addr 0x1FFFF, count 2, mode 0. Required: after the Steps the address reads 0x00000 then 0x00001 (wrap).
- Channel 0 count 0, mode 1, address 0x00500. Required: 512 Steps with the address fixed at 0x00500 and the count reading 511 after the first Step; Done after Step 512.
- Channel 2 count 10, start, 3 Steps, then Abort asserted with a Step in the same cycle. Required: IDLE with no Done; address = start+3; count = 7.
- During a channel 2 transfer, Load channel 2 bank 0 and Load channel 5 bank 0 = 0xAA. Required: channel 2 unchanged; channel 5 address[7:0]=0xAA.
- With ACTL_WRAP_EN defined: mask 0x0000F, address 0x0010E, mode 0, 3 Steps. Required: addresses 0x0010F, 0x00100, 0x00101.
